axil_sram_slave: RTL and testbench
==================================

Name: axil_sram_slave

Overview:
AXI-Lite slave that terminates the bus driven by the core's memory-system AXI-Lite master and backs it with a word-organised on-chip SRAM. It sits directly downstream of the master's five AXI-Lite channels.
- Write side: accepts AW and W independently, applies byte strobes, returns one B response per write.
- Read side: one outstanding read, data returned one cycle after address acceptance.
- Out-of-range addresses return DECERR and are never allowed to corrupt memory.

Parameters:
WIDTH, XLEN (32), data and address width in bits; WIDTH/8 byte lanes
DEPTH, 4096, memory depth in WIDTH-bit words; power of two
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  in  1  bus clock (master's m_axil_clk)
rst_n  in  1  reset, synchronous, active-low
s_axil_awaddr  in  WIDTH  write byte address
s_axil_awprot  in  3  accepted, ignored
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  WIDTH  write data
s_axil_wstrb  in  WIDTH/8  byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response, OKAY=2'b00, DECERR=2'b11
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  master accepts response
s_axil_araddr  in  WIDTH  read byte address
s_axil_arprot  in  3  accepted, ignored
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  master accepts read data

Behaviour:
- Clocking and reset: one clock, clk. rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values: bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0, AW/W hold registers empty, both FSMs idle. SRAM contents are not reset.
- Ready signals after reset: awready, wready and arready are all 1 in the first cycle after rst_n rises.
- Reset mid-transaction: drops all pending state; no memory write completes in the reset cycle.
- Address decode:
  - word index = (addr - BASE_ADDR) >> log2(WIDTH/8); addr[1:0] is ignored.
  - In range when BASE_ADDR <= addr < BASE_ADDR + DEPTH*WIDTH/8; otherwise DECERR.
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: awready = ~aw_held; wready = ~w_held.
  - A handshake on each channel latches its payload into that channel's hold register; AW and W may arrive in either order or in the same cycle.
  - Commit edge: the edge on which both payloads are available (held or handshaking this cycle).
    - In range: bytes with wstrb[i]=1 are written; wstrb=0 writes nothing but still returns OKAY.
    - Out of range: no write.
    - bresp is registered (OKAY or DECERR), bvalid=1 from the next cycle, hold registers clear, FSM moves to W_RESP.
  - Same-cycle AW+W from empty: bvalid rises exactly 1 cycle after the handshake.
  - W_RESP: awready=wready=0; bvalid and bresp are held stable until bready=1. Then bvalid=0 next cycle and the FSM returns to W_COLLECT.
  - bready may be high before bvalid.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On handshake, rdata is registered from the SRAM (0 with rresp=DECERR if out of range), rvalid=1 next cycle, FSM moves to R_DATA.
  - R_DATA: arready=0; rdata, rresp and rvalid are held stable until rready=1. Then rvalid=0 next cycle and the FSM returns to R_IDLE.
  - Back-to-back read throughput is therefore one per 2 cycles.
- Read/write collision: the read and write FSMs run independently. If an AR handshake and a write commit hit the same word on the same edge, the read returns pre-write data; a read accepted on any later edge sees the new data.
- No combinational path from any *valid input to any *ready output. Ready signals depend only on registered state.

Test Plan:
- Reset then same-cycle AW+W: addr 0x10, data 0xDEADBEEF, strb 4'hF, bready=1 -> bvalid=1 one cycle later with bresp=00; AR 0x10 -> rvalid=1 next cycle, rdata=0xDEADBEEF, rresp=00.
- W before AW: W data 0x11223344 strb 4'b0101; AW 0x10 three cycles later -> single bvalid after the AW cycle. Readback of 0x10 = 0xDE22BE44.
- Backpressure: bready=0 for 5 cycles after write, rready=0 for 4 cycles after read -> bvalid/rvalid, bresp/rresp and data stay stable, awready=wready=0 throughout, arready=0 throughout; each response retires one cycle after its ready rises.
- Out of range, DEPTH=4096: write to 0x4000 -> bresp=2'b11 and memory unchanged (word 0 readback still old value); read 0x4000 -> rresp=2'b11, rdata=0.
- Collision: word 0x20 holds 0xAAAAAAAA; commit write 0x55555555 to 0x20 on the same edge as AR 0x20 -> rdata=0xAAAAAAAA; next read -> 0x55555555.
- Reset mid-op: AW held, W not yet sent, assert rst_n=0 one cycle -> after release awready=wready=arready=1, bvalid=0, and a later W alone produces no bvalid.

Source files
------------

// File: rtl/axil_sram_slave.sv
// AXI-Lite slave backed by a word-organised on-chip SRAM.
// Independent write (collect/respond) and read (idle/data) FSMs share one array.
module axil_sram_slave #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4096,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic [WIDTH-1:0]     s_axil_awaddr,
    input  logic [2:0]           s_axil_awprot,
    input  logic                 s_axil_awvalid,
    output logic                 s_axil_awready,

    input  logic [WIDTH-1:0]     s_axil_wdata,
    input  logic [WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                 s_axil_wvalid,
    output logic                 s_axil_wready,

    output logic [1:0]           s_axil_bresp,
    output logic                 s_axil_bvalid,
    input  logic                 s_axil_bready,

    input  logic [WIDTH-1:0]     s_axil_araddr,
    input  logic [2:0]           s_axil_arprot,
    input  logic                 s_axil_arvalid,
    output logic                 s_axil_arready,

    output logic [WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]           s_axil_rresp,
    output logic                 s_axil_rvalid,
    input  logic                 s_axil_rready
);

    localparam int               STRB_W     = WIDTH / 8;
    localparam int               BYTE_SHIFT = $clog2(STRB_W);
    localparam int               IDX_W      = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] DEPTH_LIM  = WIDTH'(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [0:0] W_COLLECT = 1'b0;
    localparam logic [0:0] W_RESP    = 1'b1;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_DATA    = 1'b1;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [0:0]        w_state;
    logic              aw_held;
    logic              w_held;
    logic [WIDTH-1:0]  awaddr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [1:0]        bresp_q;

    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic [WIDTH-1:0]  wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [WIDTH-1:0]  wr_off;
    logic              wr_in_range;
    logic [IDX_W-1:0]  wr_idx;

    logic [0:0]        r_state;
    logic [WIDTH-1:0]  rdata_q;
    logic [1:0]        rresp_q;
    logic [WIDTH-1:0]  rd_off;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;

    logic              unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    // Readies come from registered state only, never from the valids.
    assign s_axil_awready = (w_state == W_COLLECT) && !aw_held;
    assign s_axil_wready  = (w_state == W_COLLECT) && !w_held;
    assign s_axil_bvalid  = (w_state == W_RESP);
    assign s_axil_bresp   = bresp_q;

    assign s_axil_arready = (r_state == R_IDLE);
    assign s_axil_rvalid  = (r_state == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;

    // A channel's payload counts as available either from its hold register or a live handshake.
    assign commit  = (w_state == W_COLLECT) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_addr = aw_held ? awaddr_q : s_axil_awaddr;
    assign wr_data = w_held ? wdata_q : s_axil_wdata;
    assign wr_strb = w_held ? wstrb_q : s_axil_wstrb;

    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_in_range = (wr_addr >= BASE_ADDR) && ((wr_off >> BYTE_SHIFT) < DEPTH_LIM);
    assign wr_idx      = wr_off[BYTE_SHIFT +: IDX_W];

    assign rd_off      = s_axil_araddr - BASE_ADDR;
    assign rd_in_range = (s_axil_araddr >= BASE_ADDR) && ((rd_off >> BYTE_SHIFT) < DEPTH_LIM);
    assign rd_idx      = rd_off[BYTE_SHIFT +: IDX_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state  <= W_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else if (w_state == W_COLLECT) begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                w_state <= W_RESP;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= s_axil_awaddr;
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= s_axil_wdata;
                    wstrb_q <= s_axil_wstrb;
                end
            end
        end else if (s_axil_bready) begin
            w_state <= W_COLLECT;
        end
    end

    // SRAM array is never reset; rst_n only blocks a commit landing in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst_n && commit && wr_in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Non-blocking array update means a same-edge read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (r_state == R_IDLE) begin
            if (s_axil_arvalid) begin
                r_state <= R_DATA;
                rdata_q <= rd_in_range ? mem[rd_idx] : '0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_DECERR;
            end
        end else if (s_axil_rready) begin
            r_state <= R_IDLE;
        end
    end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Bench for axil_sram_slave: directed bring-up cases plus randomized traffic,
// checked every cycle against a transaction-level memory model.
module tb_axil_sram_slave;

    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  DECERR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [31:0] s_axil_araddr = '0;
    logic [2:0]  s_axil_arprot = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;

    always #5 clk = ~clk;

    axil_sram_slave #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];
    logic [31:0] model_mem [int];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: handshake never happened within its cycle budget at %0t", name, $time);
    endtask

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned la = 64'(a);
        longint unsigned lo = 64'(BASE);
        longint unsigned hi = lo + 64'(DEPTH) * 4;
        return (la >= lo) && (la < hi);
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        logic [31:0] w;
        if (!in_range(a)) return;
        idx = word_idx(a);
        w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        model_mem[idx] = w;
    endfunction

    function automatic rexp_t model_read(input logic [31:0] a);
        rexp_t r;
        if (in_range(a)) begin
            r.data = model_mem[word_idx(a)];
            r.resp = OKAY;
        end else begin
            r.data = 32'h0;
            r.resp = DECERR;
        end
        return r;
    endfunction

    // Every cycle: outputs must match what the queued transactions say they should be.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            checkOutput("bvalid", 64'(s_axil_bvalid), 64'(exp_b.size() != 0));
            checkOutput("rvalid", 64'(s_axil_rvalid), 64'(exp_r.size() != 0));
            checkOutput("arready", 64'(s_axil_arready), 64'(exp_r.size() == 0));
            if (exp_b.size() != 0) begin
                checkOutput("bresp", 64'(s_axil_bresp), 64'(exp_b[0]));
                checkOutput("aw_w_ready_in_resp", 64'({s_axil_awready, s_axil_wready}), 64'(2'b00));
                if (s_axil_bvalid && s_axil_bready) void'(exp_b.pop_front());
            end
            if (exp_r.size() != 0) begin
                checkOutput("rdata", 64'(s_axil_rdata), 64'(exp_r[0].data));
                checkOutput("rresp", 64'(s_axil_rresp), 64'(exp_r[0].resp));
                if (s_axil_rvalid && s_axil_rready) void'(exp_r.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int aw_dly, input int w_dly, input int bp);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_fire, w_fire, fire;
        int cyc = 0;
        s_axil_awaddr = addr;
        s_axil_awprot = 3'($urandom_range(0, 7));
        s_axil_wdata  = data;
        s_axil_wstrb  = strb;
        s_axil_bready = (bp == 0);
        while (!(aw_done && w_done)) begin
            s_axil_awvalid = !aw_done && (cyc >= aw_dly);
            s_axil_wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_fire = s_axil_awvalid && s_axil_awready;
            w_fire  = s_axil_wvalid && s_axil_wready;
            @(posedge clk);
            #1;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
            if (cyc > 50) begin
                report_timeout("aw_w_accept");
                s_axil_awvalid = 1'b0;
                s_axil_wvalid  = 1'b0;
                return;
            end
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        exp_b.push_back(in_range(addr) ? OKAY : DECERR);
        model_write(addr, data, strb);
        cyc = 0;
        do begin
            @(negedge clk);
            fire = s_axil_bvalid && s_axil_bready;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= bp) s_axil_bready = 1'b1;
        end while (!fire && cyc < bp + 20);
        if (!fire) report_timeout("b_handshake");
        s_axil_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int rp, input bit use_lit,
                           input logic [31:0] lit_data, input logic [1:0] lit_resp);
        rexp_t snap;
        bit fire;
        int cyc = 0;
        s_axil_araddr  = addr;
        s_axil_arprot  = 3'($urandom_range(0, 7));
        s_axil_arvalid = 1'b1;
        s_axil_rready  = (rp == 0);
        do begin
            @(negedge clk);
            snap = model_read(addr);
            fire = s_axil_arvalid && s_axil_arready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!fire && cyc < 50);
        s_axil_arvalid = 1'b0;
        if (!fire) begin
            report_timeout("ar_accept");
            return;
        end
        exp_r.push_back(snap);
        cyc = 0;
        do begin
            @(negedge clk);
            if (cyc == 0 && use_lit) begin
                checkOutput("rdata_literal", 64'(s_axil_rdata), 64'(lit_data));
                checkOutput("rresp_literal", 64'(s_axil_rresp), 64'(lit_resp));
            end
            fire = s_axil_rvalid && s_axil_rready;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= rp) s_axil_rready = 1'b1;
        end while (!fire && cyc < rp + 20);
        if (!fire) report_timeout("r_handshake");
        s_axil_rready = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return 32'h4000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] old_word;
        bit          fire;
        int          cyc;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_awready", 64'(s_axil_awready), 64'(1));
        checkOutput("reset_wready", 64'(s_axil_wready), 64'(1));
        checkOutput("reset_arready", 64'(s_axil_arready), 64'(1));
        checkOutput("reset_bvalid", 64'(s_axil_bvalid), 64'(0));
        checkOutput("reset_rvalid", 64'(s_axil_rvalid), 64'(0));
        checkOutput("reset_bresp", 64'(s_axil_bresp), 64'(0));
        checkOutput("reset_rresp", 64'(s_axil_rresp), 64'(0));
        checkOutput("reset_rdata", 64'(s_axil_rdata), 64'(0));
        @(posedge clk);
        #1;

        $display("[TB] same-cycle AW+W then readback");
        applyStimulus(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(32'h10, 0, 1'b1, 32'hDEAD_BEEF, OKAY);

        $display("[TB] W ahead of AW with partial strobes");
        applyStimulus(32'h10, 32'h1122_3344, 4'b0101, 3, 0, 0);
        do_read(32'h10, 0, 1'b1, 32'hDE22_BE44, OKAY);

        for (int i = 0; i < 16; i++) begin
            if (i != 4) applyStimulus(32'(i) * 4, $urandom, 4'hF, 0, 0, 0);
        end

        $display("[TB] response backpressure");
        applyStimulus(32'h08, 32'h0BAD_CAFE, 4'hF, 1, 0, 5);
        do_read(32'h08, 4, 1'b1, 32'h0BAD_CAFE, OKAY);

        $display("[TB] out-of-range accesses");
        applyStimulus(32'h0, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        applyStimulus(32'h4000, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_read(32'h0, 0, 1'b1, 32'hCAFE_F00D, OKAY);
        do_read(32'h4000, 0, 1'b1, 32'h0, DECERR);

        $display("[TB] read/write collision on one word");
        applyStimulus(32'h20, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
        fork
            applyStimulus(32'h20, 32'h5555_5555, 4'hF, 0, 0, 0);
            do_read(32'h20, 0, 1'b1, 32'hAAAA_AAAA, OKAY);
        join
        do_read(32'h20, 0, 1'b1, 32'h5555_5555, OKAY);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 150; it++) begin
            logic [31:0] wa, ra, wd;
            logic [3:0]  ws;
            int          kind, awd, wdl, bp, rp;
            kind = int'($urandom_range(0, 2));
            wa   = rand_addr();
            ra   = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
            wd   = $urandom;
            ws   = 4'($urandom_range(0, 15));
            awd  = int'($urandom_range(0, 3));
            wdl  = int'($urandom_range(0, 3));
            bp   = int'($urandom_range(0, 3));
            rp   = int'($urandom_range(0, 3));
            case (kind)
                0: applyStimulus(wa, wd, ws, awd, wdl, bp);
                1: do_read(ra, rp, 1'b0, 32'h0, OKAY);
                default: begin
                    fork
                        applyStimulus(wa, wd, ws, awd, wdl, bp);
                        do_read(ra, rp, 1'b0, 32'h0, OKAY);
                    join
                end
            endcase
        end

        $display("[TB] reset with AW held and W pending");
        s_axil_awaddr  = 32'h10;
        s_axil_awvalid = 1'b1;
        @(negedge clk);
        checkOutput("mid_awready", 64'(s_axil_awready), 64'(1));
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0;
        old_word = model_mem[4];
        rst_n         = 1'b0;
        s_axil_wdata  = ~old_word;
        s_axil_wstrb  = 4'hF;
        s_axil_wvalid = 1'b1;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        s_axil_wvalid = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_awready", 64'(s_axil_awready), 64'(1));
        checkOutput("post_reset_wready", 64'(s_axil_wready), 64'(1));
        checkOutput("post_reset_arready", 64'(s_axil_arready), 64'(1));
        checkOutput("post_reset_bvalid", 64'(s_axil_bvalid), 64'(0));
        @(posedge clk);
        #1;
        do_read(32'h10, 0, 1'b1, old_word, OKAY);
        s_axil_wvalid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            fire = s_axil_wvalid && s_axil_wready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!fire && cyc < 10);
        s_axil_wvalid = 1'b0;
        if (!fire) report_timeout("lone_w_accept");
        repeat (6) begin
            @(negedge clk);
            checkOutput("lone_w_no_bvalid", 64'(s_axil_bvalid), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
